// File: rtl/angle_quadrant_reducer_if.sv
// Handshake bundle between the angle source, the quadrant reducer and the trig LUT stages.
// The slave modport is the reducer's view; the master modport is the view of whatever drives and consumes it.
interface angle_quadrant_reducer_if #(
  parameter int ANGLE_WIDTH = 16,
  parameter int DATA_WIDTH  = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [ANGLE_WIDTH-1:0] angle_in;
  logic [1:0]             func_sel;
  logic                   out_valid;
  logic                   out_ready;
  logic [1:0]             quadrant;
  logic [DATA_WIDTH-1:0]  ref_angle;
  logic                   en_sine;
  logic                   en_cosine;
  logic                   en_tangent;
  logic                   en_cotangent;

  modport slave (
    input  in_valid, angle_in, func_sel, out_ready,
    output in_ready, out_valid, quadrant, ref_angle,
           en_sine, en_cosine, en_tangent, en_cotangent
  );

  modport master (
    output in_valid, angle_in, func_sel, out_ready,
    input  in_ready, out_valid, quadrant, ref_angle,
           en_sine, en_cosine, en_tangent, en_cotangent
  );
endinterface

// File: rtl/angle_quadrant_reducer.sv
// Reduces an unsigned degree angle modulo 360 by restoring subtraction, then folds it into a
// quadrant plus 0..90 reference angle and raises the one-hot enable of the selected trig LUT.
module angle_quadrant_reducer #(
  parameter int ANGLE_WIDTH = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int RED_STEPS   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  angle_quadrant_reducer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REDUCE, CLASSIFY, DONE} state_t;

  // One extra bit so 360 << (RED_STEPS-1) = 46080 fits alongside a full 16-bit angle.
  localparam int REM_W = ANGLE_WIDTH + 1;
  localparam int K_W   = $clog2(RED_STEPS);
  localparam int REF_W = 9;

  state_t             state_q;
  logic [REM_W-1:0]   rem_q;
  logic [REM_W-1:0]   rem_d;
  logic [REM_W-1:0]   sub_d;
  logic [K_W-1:0]     k_q;
  logic [1:0]         func_q;
  logic [1:0]         quadrant_q;
  logic [REF_W-1:0]   ref_q;
  logic               out_valid_q;
  logic [3:0]         en_q;

  // Returns {quadrant, reference angle} for a remainder already below 360.
  function automatic logic [REF_W+1:0] classify(input logic [REM_W-1:0] r);
    logic [REF_W+1:0] res;
    if (r <= REM_W'(90))
      res = {2'd0, REF_W'(r)};
    else if (r <= REM_W'(180))
      res = {2'd1, REF_W'(REM_W'(180) - r)};
    else if (r <= REM_W'(270))
      res = {2'd2, REF_W'(r - REM_W'(180))};
    else
      res = {2'd3, REF_W'(REM_W'(360) - r)};
    return res;
  endfunction

  always_comb begin
    sub_d = REM_W'(360) << k_q;
    rem_d = (rem_q >= sub_d) ? (rem_q - sub_d) : rem_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      k_q         <= '0;
      func_q      <= '0;
      quadrant_q  <= '0;
      ref_q       <= '0;
      out_valid_q <= 1'b0;
      en_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            rem_q   <= REM_W'(bus.angle_in);
            func_q  <= bus.func_sel;
            k_q     <= K_W'(RED_STEPS - 1);
            state_q <= REDUCE;
          end
        end
        // One restoring step per cycle, largest multiple of 360 first.
        REDUCE: begin
          rem_q <= rem_d;
          k_q   <= k_q - K_W'(1);
          if (k_q == '0)
            state_q <= CLASSIFY;
        end
        CLASSIFY: begin
          {quadrant_q, ref_q} <= classify(rem_q);
          out_valid_q         <= 1'b1;
          en_q                <= 4'b0001 << func_q;
          state_q             <= DONE;
        end
        // Hold the result; quadrant/ref stay as-is after retirement.
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            en_q        <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.quadrant     = quadrant_q;
  assign bus.ref_angle    = DATA_WIDTH'(ref_q);
  assign bus.en_sine      = en_q[0];
  assign bus.en_cosine    = en_q[1];
  assign bus.en_tangent   = en_q[2];
  assign bus.en_cotangent = en_q[3];
endmodule

// File: tb/tb_angle_quadrant_reducer.sv
// Directed and randomized checks of angle_quadrant_reducer against an arithmetic (mod 360) reference model.
module tb_angle_quadrant_reducer;
  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  angle_quadrant_reducer_if #(.ANGLE_WIDTH(16), .DATA_WIDTH(32)) bus ();

  angle_quadrant_reducer #(.ANGLE_WIDTH(16), .DATA_WIDTH(32), .RED_STEPS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] en_vec();
    return {bus.en_cotangent, bus.en_tangent, bus.en_cosine, bus.en_sine};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: reduce by plain modulo, then fold into a quadrant.
  task automatic model(input int a, output int q, output int r);
    int m;
    m = a % 360;
    if (m <= 90)       begin q = 0; r = m;       end
    else if (m <= 180) begin q = 1; r = 180 - m; end
    else if (m <= 270) begin q = 2; r = m - 180; end
    else               begin q = 3; r = 360 - m; end
  endtask

  task automatic send(input int a, input int f);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.angle_in = 16'(a);
    bus.func_sel = 2'(f);
    check("in_ready_before_accept", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.angle_in = 16'($urandom);
    bus.func_sel = 2'($urandom);
  endtask

  // Called 1ns after the accepting edge; counts edges until out_valid.
  task automatic expect_res(input string tag, input int a, input int f);
    int q, r, lat;
    model(a, q, r);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 9);
    check({tag, "_quadrant"}, bus.quadrant, q);
    check({tag, "_ref_angle"}, bus.ref_angle, r);
    check({tag, "_enables"}, en_vec(), 4'b0001 << f);
  endtask

  task automatic retire(input bit keep_ready);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("retire_out_valid", bus.out_valid, 0);
    check("retire_in_ready", bus.in_ready, 1);
    check("retire_enables", en_vec(), 0);
    bus.out_ready = keep_ready;
  endtask

  initial begin
    int da [9];
    int df [9];
    int q_hold, r_hold, stray, a, f;
    logic [3:0] en_hold;

    da = '{0, 135, 359, 90, 180, 360, 725, 65535, 270};
    df = '{0, 3, 2, 1, 0, 2, 3, 1, 2};

    bus.in_valid  = 1'b0;
    bus.angle_in  = '0;
    bus.func_sel  = '0;
    bus.out_ready = 1'b0;
    reset_n       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_quadrant", bus.quadrant, 0);
    check("reset_ref_angle", bus.ref_angle, 0);
    check("reset_enables", en_vec(), 0);
    check("reset_in_ready", bus.in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      send(da[i], df[i]);
      expect_res($sformatf("directed_%0d", da[i]), da[i], df[i]);
      retire(1'b0);
    end

    // Backpressure: result must hold while new requests are ignored.
    send(200, 1);
    expect_res("bp", 200, 1);
    q_hold  = int'(bus.quadrant);
    r_hold  = int'(bus.ref_angle);
    en_hold = en_vec();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.angle_in = 16'd45;
      bus.func_sel = 2'd0;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_quadrant", bus.quadrant, q_hold);
      check("bp_ref_angle", bus.ref_angle, r_hold);
      check("bp_enables", en_vec(), en_hold);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    retire(1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("bp_ignored_no_result", bus.out_valid, 0);
    check("bp_ignored_in_ready", bus.in_ready, 1);

    // Retire and new request together: the request waits for the next IDLE cycle.
    send(500, 2);
    expect_res("simul_first", 500, 2);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.angle_in  = 16'd300;
    bus.func_sel  = 2'd1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("simul_retired", bus.out_valid, 0);
    check("simul_idle", bus.in_ready, 1);
    @(posedge clk);
    #1;
    check("simul_accepted", bus.in_ready, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.angle_in  = 16'($urandom);
    expect_res("simul_second", 300, 1);
    retire(1'b0);

    // Asynchronous reset in the middle of reduction.
    send(1000, 3);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_quadrant", bus.quadrant, 0);
    check("midrst_ref_angle", bus.ref_angle, 0);
    check("midrst_enables", en_vec(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) stray++;
    end
    check("midrst_no_stray_valid", stray, 0);

    // Back-to-back random traffic with the sink always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(0, 65535));
      f = int'($urandom_range(0, 3));
      send(a, f);
      expect_res($sformatf("rand_%0d_a%0d", i, a), a, f);
      retire(1'b1);
    end
    bus.out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
